imm_extender_pipe: RTL and testbench

Parametrised, registered immediate-extension unit for the datapath's decode stage. It accepts an IN_W-bit immediate field plus a mode select over a valid/ready handshake, then produces an OUT_W-bit operand. Modes are zero-extend, sign-extend, scaled sign-extend (branch offsets) and upper-placement. A 2-entry output buffer lets decode keep issuing while execute stalls for one cycle.

---
 rtl/imm_extender_pipe.sv | 111 +++++++++++
 tb/tb_imm_extender_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_extender_pipe.sv
// rtl/imm_extender_pipe.sv - registered immediate extender with 2-entry output FIFO
// Optional overflow flag for scaled mode built when IMM_EXT_OVF_EN is defined.
module imm_extender_pipe #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    logic [OUT_W-1:0] zext_val, sext_val, scaled_val, upper_val, ext_val;
    logic             push, pop;

    logic [OUT_W-1:0] data_q [2];
    logic [OUT_W-1:0] data_d [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        zext_val   = OUT_W'(in_imm);
        sext_val   = OUT_W'($signed(in_imm));
        scaled_val = sext_val << SHIFT;
        upper_val  = zext_val << (OUT_W - IN_W);
        unique case (in_mode)
            2'b00:   ext_val = zext_val;
            2'b01:   ext_val = sext_val;
            2'b10:   ext_val = scaled_val;
            default: ext_val = upper_val;
        endcase
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = data_q[head_q];

    always_comb begin
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            data_d[tail_q] = ext_val;
            tail_d         = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '{default: '0};
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef IMM_EXT_OVF_EN
    logic [OUT_W+SHIFT-1:0] wide_val;
    logic                   ext_ovf;
    logic                   ovf_q [2];
    logic                   ovf_d [2];

    // Overflow when the untruncated scaled value differs from its truncated, re-sign-extended form.
    always_comb begin
        wide_val = (OUT_W+SHIFT)'($signed(in_imm)) << SHIFT;
        ext_ovf  = (in_mode == 2'b10) &&
                   (wide_val != (OUT_W+SHIFT)'($signed(wide_val[OUT_W-1:0])));
        ovf_d = ovf_q;
        if (push) begin
            ovf_d[tail_q] = ext_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= '{default: 1'b0};
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q[head_q];
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_imm_extender_pipe.sv
// tb/tb_imm_extender_pipe.sv - self-checking bench for imm_extender_pipe
module tb_imm_extender_pipe;

`ifdef IMM_EXT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [2:0] in_imm;
    logic [1:0] in_mode;
    logic [7:0] out_data;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_ovf4;
    logic [3:0] in_imm4, out_data4;
    logic [1:0] in_mode4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_extender_pipe #(.IN_W(3), .OUT_W(8), .SHIFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    imm_extender_pipe #(.IN_W(4), .OUT_W(4), .SHIFT(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_imm(in_imm4), .in_mode(in_mode4), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_data(out_data4), .out_ovf(out_ovf4)
    );

    // Arithmetic reference: signed integer value, then reduce modulo 2^out_w.
    function automatic void model(input int imm, input int mode, input int in_w,
                                  input int out_w, input int shift,
                                  output int data, output bit ovf);
        int sx, v;
        sx  = (imm >= (1 << (in_w - 1))) ? imm - (1 << in_w) : imm;
        ovf = 1'b0;
        case (mode)
            0: v = imm;
            1: v = sx;
            2: begin
                v = sx * (1 << shift);
                ovf = OVF_EN && ((v < -(1 << (out_w - 1))) || (v >= (1 << (out_w - 1))));
            end
            default: v = imm * (1 << (out_w - in_w));
        endcase
        data = v & ((1 << out_w) - 1);
    endfunction

    task automatic apply(input logic [2:0] imm, input logic [1:0] mode);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1; in_imm = 3'b111; in_mode = 2'b01; out_ready = 1'b0;
        in_valid4 = 1'b0; in_imm4 = '0; in_mode4 = '0; out_ready4 = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sign_ext();
        apply(3'b101, 2'b01);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hFD) begin errors++; $display("FAIL sext_101 got v=%b %h want v=1 fd", out_valid, out_data); end
        apply(3'b011, 2'b01);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin errors++; $display("FAIL sext_011 got v=%b %h want v=1 03", out_valid, out_data); end
    endtask

    task automatic test_zero_upper();
        apply(3'b101, 2'b00);
        checks++; if (out_data !== 8'h05) begin errors++; $display("FAIL zext_101 got %h want 05", out_data); end
        apply(3'b101, 2'b11);
        checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL upper_101 got %h want a0", out_data); end
        apply(3'b111, 2'b11);
        checks++; if (out_data !== 8'hE0) begin errors++; $display("FAIL upper_111 got %h want e0", out_data); end
    endtask

    task automatic test_scaled();
        apply(3'b110, 2'b10);
        checks++; if (out_data !== 8'hFC || out_ovf !== 1'b0) begin errors++; $display("FAIL scaled_110 got %h ovf=%b want fc ovf=0", out_data, out_ovf); end
        apply(3'b011, 2'b10);
        checks++; if (out_data !== 8'h06) begin errors++; $display("FAIL scaled_011 got %h want 06", out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'b00; in_imm = 3'd1;
        @(negedge clk);
        in_imm = 3'd2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after1 got %b want 1", in_ready); end
        @(negedge clk);
        in_imm = 3'd3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_data !== 8'h01) begin errors++; $display("FAIL bp_hold got rdy=%b %h want rdy=0 01", in_ready, out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_data !== 8'h02 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1 got %h rdy=%b want 02 rdy=1", out_data, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin errors++; $display("FAIL bp_third got v=%b %h want v=1 03", out_valid, out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        apply(3'b001, 2'b00);
        apply(3'b010, 2'b00);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rm_full got %b want 0", in_ready); end
        rst_n = 1'b0;
        in_valid = 1'b1; in_imm = 3'b111; in_mode = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_state got v=%b %h rdy=%b want v=0 00 rdy=1", out_valid, out_data, in_ready); end
        out_ready = 1'b1;
        apply(3'b100, 2'b01);
        checks++; if (out_data !== 8'hFC) begin errors++; $display("FAIL rm_after got %h want fc", out_data); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        logic [3:0] imms [2];
        int  ed;
        bit  eo;
        imms[0] = 4'b0100;
        imms[1] = 4'b1110;
        for (int i = 0; i < 2; i++) begin
            model(int'(imms[i]), 2, 4, 4, 1, ed, eo);
            in_valid4 = 1'b1; in_imm4 = imms[i]; in_mode4 = 2'b10;
            @(negedge clk);
            in_valid4 = 1'b0;
            checks++;
            if (out_valid4 !== 1'b1 || out_data4 !== 4'(ed) || out_ovf4 !== eo) begin
                errors++;
                $display("FAIL ovf_%0d got v=%b %h ovf=%b want v=1 %h ovf=%b", i, out_valid4, out_data4, out_ovf4, 4'(ed), eo);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int  q_data[$];
        bit  q_ovf[$];
        int  ed;
        bit  eo;
        bit  do_push, do_pop;
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (in_ready !== (q_data.size() != 2) || out_valid !== (q_data.size() != 0)) begin
                errors++;
                $display("FAIL rnd_flags cyc %0d got rdy=%b v=%b want depth %0d", c, in_ready, out_valid, q_data.size());
            end
            if (q_data.size() != 0) begin
                checks++;
                if (out_data !== 8'(q_data[0]) || out_ovf !== q_ovf[0]) begin
                    errors++;
                    $display("FAIL rnd_data cyc %0d got %h ovf=%b want %h ovf=%b", c, out_data, out_ovf, 8'(q_data[0]), q_ovf[0]);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_imm    = 3'($urandom);
            in_mode   = 2'($urandom);
            do_push = in_valid && (q_data.size() != 2);
            do_pop  = out_ready && (q_data.size() != 0);
            model(int'(in_imm), int'(in_mode), 3, 8, 1, ed, eo);
            @(negedge clk);
            if (do_pop) begin
                void'(q_data.pop_front());
                void'(q_ovf.pop_front());
            end
            if (do_push) begin
                q_data.push_back(ed);
                q_ovf.push_back(eo);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_sign_ext();
        test_zero_upper();
        test_scaled();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
